// File: rtl/input_random_unit.sv
`default_nettype none
// ============================================================================
//  Module   : input_random_unit
//  Purpose  : Four debounced push-button channels producing one-cycle press
//             pulses, plus a free-running 8-bit Fibonacci LFSR that supplies
//             a random piece index (0..6) and rotation index (0..3).
//  Revision : 1.0  initial release
// ============================================================================
module input_random_unit #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       down_btn,
  input  logic       right_btn,
  input  logic       left_btn,
  input  logic       rotate_btn,
  output logic       down_signal,
  output logic       right_signal,
  output logic       left_signal,
  output logic       rotate_signal,
  output logic [7:0] random,
  output logic [2:0] random_piece,
  output logic [1:0] random_rotate
);

  // Last count value before a differing level is accepted as the new level.
  localparam logic [19:0] c_CNT_LAST = DEBOUNCE_CYCLES - 20'd1;
  localparam int          c_NUM_BTN  = 4;

  // Channel order: 0 down, 1 right, 2 left, 3 rotate.
  logic [c_NUM_BTN-1:0] w_btn;
  logic [c_NUM_BTN-1:0] w_pulse;

  assign w_btn = {rotate_btn, left_btn, right_btn, down_btn};

  assign down_signal   = w_pulse[0];
  assign right_signal  = w_pulse[1];
  assign left_signal   = w_pulse[2];
  assign rotate_signal = w_pulse[3];

  // --------------------------------------------------------------------------
  // Button channels: synchronize, debounce, and emit a pulse on acceptance of
  // a new high level. Channels share nothing, so simultaneous presses pulse
  // independently (possibly in the same cycle).
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < c_NUM_BTN; gi++) begin : g_chan
      logic        sync1_q;
      logic        sync2_q;
      logic        stable_q;
      logic        stable_d;
      logic        pulse_q;
      logic        pulse_d;
      logic [19:0] cnt_q;
      logic [19:0] cnt_d;

      // Debounce next-state: count while the synchronized level disagrees
      // with the accepted level; accept after DEBOUNCE_CYCLES such cycles.
      always_comb begin
        stable_d = stable_q;
        cnt_d    = 20'd0;
        pulse_d  = 1'b0;
        if (sync2_q != stable_q) begin
          if (cnt_q == c_CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = 20'd0;
            // Pulse only on an accepted rising level; release is silent.
            pulse_d  = sync2_q;
          end else begin
            cnt_d = cnt_q + 20'd1;
          end
        end
      end

      // Synchronizer, debounce state and pulse register with async reset.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync1_q  <= 1'b0;
          sync2_q  <= 1'b0;
          stable_q <= 1'b0;
          cnt_q    <= 20'd0;
          pulse_q  <= 1'b0;
        end else begin
          sync1_q  <= w_btn[gi];
          sync2_q  <= sync1_q;
          stable_q <= stable_d;
          cnt_q    <= cnt_d;
          pulse_q  <= pulse_d;
        end
      end

      assign w_pulse[gi] = pulse_q;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Random source: x^8+x^6+x^5+x^4+1 Fibonacci LFSR, free-running.
  // --------------------------------------------------------------------------
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // LFSR next state; the all-zero lock-up state is forced back to 8'h01.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    if (lfsr_q == 8'h00) begin
      lfsr_d = 8'h01;
    end
  end

  // LFSR register; advances every cycle once out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= 8'h01;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign random        = lfsr_q;
  assign random_rotate = lfsr_q[7:6];
  // Seven pieces only: fold the unused code 7 onto piece 1.
  assign random_piece  = (lfsr_q[2:0] == 3'b111) ? 3'b001 : lfsr_q[2:0];

endmodule
`default_nettype wire

// File: tb/tb_input_random_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_random_unit
//  Purpose  : Directed self-checking bench for input_random_unit with
//             DEBOUNCE_CYCLES = 4.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_input_random_unit;

  logic       clk;
  logic       reset_n;
  logic       down_btn;
  logic       right_btn;
  logic       left_btn;
  logic       rotate_btn;
  logic       down_signal;
  logic       right_signal;
  logic       left_signal;
  logic       rotate_signal;
  logic [7:0] random;
  logic [2:0] random_piece;
  logic [1:0] random_rotate;

  int checks   = 0;
  int failures = 0;

  input_random_unit #(
    .DEBOUNCE_CYCLES(20'd4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .down_btn     (down_btn),
    .right_btn    (right_btn),
    .left_btn     (left_btn),
    .rotate_btn   (rotate_btn),
    .down_signal  (down_signal),
    .right_signal (right_signal),
    .left_signal  (left_signal),
    .rotate_signal(rotate_signal),
    .random       (random),
    .random_piece (random_piece),
    .random_rotate(random_rotate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [2:0] piece_of(input logic [7:0] s);
    return (s[2:0] == 3'b111) ? 3'b001 : s[2:0];
  endfunction

  logic [7:0] exp_seq   [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
  logic [2:0] exp_piece [5] = '{3'd1, 3'd2, 3'd4, 3'd0, 3'd1};

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m;
    bit         seen [256];
    int         distinct;

    reset_n    = 1'b0;
    down_btn   = 1'b0;
    right_btn  = 1'b0;
    left_btn   = 1'b0;
    rotate_btn = 1'b0;

    // Reset held while the clock runs: everything at reset values.
    repeat (3) tick();
    check_eq("rst_random", random, 8'h01);
    check_eq("rst_piece", random_piece, 3'd1);
    check_eq("rst_rotate", random_rotate, 2'd0);
    check_eq("rst_signals", {down_signal, right_signal, left_signal, rotate_signal}, 4'b0);

    // Release; sequence 01,02,04,08,11 on successive edges.
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      check_eq("seq_random", random, exp_seq[i]);
      check_eq("seq_piece", random_piece, exp_piece[i]);
      check_eq("seq_rotate", random_rotate, 2'd0);
      check_eq("seq_signals", {down_signal, right_signal, left_signal, rotate_signal}, 4'b0);
    end

    // down held 20 cycles: pulse only after edge index 5 (2 sync + 4 stable).
    down_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("down_pulse", down_signal, (i == 5));
      check_eq("down_others", {right_signal, left_signal, rotate_signal}, 3'b0);
    end
    down_btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("down_release", down_signal, 1'b0);
    end

    // rotate glitch of 3 cycles: never accepted.
    rotate_btn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("glitch_rotate", rotate_signal, 1'b0);
    end
    rotate_btn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("glitch_rotate", rotate_signal, 1'b0);
    end

    // left and right rise together: pulse in the same single cycle.
    left_btn  = 1'b1;
    right_btn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("lr_left", left_signal, (i == 5));
      check_eq("lr_right", right_signal, (i == 5));
      check_eq("lr_others", {down_signal, rotate_signal}, 2'b0);
    end
    left_btn  = 1'b0;
    right_btn = 1'b0;
    repeat (10) tick();

    // Full LFSR period from reset.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m = 8'h01;
    check_eq("per_start", random, 8'h01);
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    seen[random] = 1'b1;
    distinct = 1;
    for (int i = 1; i < 255; i++) begin
      tick();
      m = lfsr_next(m);
      check_eq("per_random", random, m);
      check_eq("per_piece", random_piece, piece_of(m));
      check_eq("per_rotate", random_rotate, m[7:6]);
      check_eq("per_piece_not7", (random_piece == 3'd7), 1'b0);
      check_eq("per_unique", seen[random], 1'b0);
      if (!seen[random]) distinct++;
      seen[random] = 1'b1;
    end
    check_eq("per_distinct", distinct, 255);
    check_eq("per_zero_unseen", seen[0], 1'b0);
    tick();
    check_eq("per_wrap", random, 8'h01);

    // Asynchronous reset mid-count with down held, then a fresh press.
    down_btn = 1'b1;
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_random", random, 8'h01);
    check_eq("async_signals", {down_signal, right_signal, left_signal, rotate_signal}, 4'b0);
    repeat (3) tick();
    check_eq("hold_random", random, 8'h01);
    check_eq("hold_down", down_signal, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) check_eq("post_rst_random", random, 8'h02);
      check_eq("post_rst_down", down_signal, (i == 5));
    end
    down_btn = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
